// File: rtl/lsu_pkg.sv
// Shared size codes, FSM state type and access legality check for the load/store unit.
package lsu_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned SZW  = 3;

    localparam logic [SZW-1:0] SIZE_B  = 3'd0;
    localparam logic [SZW-1:0] SIZE_H  = 3'd1;
    localparam logic [SZW-1:0] SIZE_W  = 3'd2;
    localparam logic [SZW-1:0] SIZE_BU = 3'd4;
    localparam logic [SZW-1:0] SIZE_HU = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LOAD_DATA = 2'd1,
        ST_RMW_MERGE = 2'd2
    } state_e;

    // True when the access uses an undefined size, an unsigned store, or is misaligned.
    function automatic logic access_bad(input logic we, input logic [SZW-1:0] size,
                                        input logic [1:0] addr_lo);
        logic bad;
        bad = 1'b0;
        case (size)
            SIZE_B:  bad = 1'b0;
            SIZE_BU: bad = we;
            SIZE_H:  bad = addr_lo[0];
            SIZE_HU: bad = we | addr_lo[0];
            SIZE_W:  bad = |addr_lo;
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Byte-lane steering: load extraction/extension and sub-word store merge.
module lsu_byte_lane
    import lsu_pkg::*;
(
    input  logic [SZW-1:0]  size,
    input  logic [1:0]      addr_lo,
    input  logic [XLEN-1:0] rd_word,
    input  logic [15:0]     wd,
    output logic [XLEN-1:0] load_data,
    output logic [XLEN-1:0] merge_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed lane and extend it to a full word.
    always_comb begin
        byte_sel  = rd_word[{addr_lo, 3'b000} +: 8];
        half_sel  = addr_lo[1] ? rd_word[31:16] : rd_word[15:0];
        load_data = rd_word;
        case (size)
            SIZE_B:  load_data = {{24{byte_sel[7]}}, byte_sel};
            SIZE_BU: load_data = {24'd0, byte_sel};
            SIZE_H:  load_data = {{16{half_sel[15]}}, half_sel};
            SIZE_HU: load_data = {16'd0, half_sel};
            default: load_data = rd_word;
        endcase
    end

    // Replace the addressed byte or half of the old word with the store data.
    always_comb begin
        merge_data = rd_word;
        if (size == SIZE_B) begin
            merge_data[{addr_lo, 3'b000} +: 8] = wd[7:0];
        end else begin
            merge_data[{addr_lo[1], 4'b0000} +: 16] = wd;
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: sized loads with extension, single-cycle word stores,
// read-modify-write for byte/half stores against a sync-read data memory.
module load_store_unit
    import lsu_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            core_req_i,
    input  logic            core_we_i,
    input  logic [SZW-1:0]  core_size_i,
    input  logic [XLEN-1:0] core_addr_i,
    input  logic [XLEN-1:0] core_wd_i,
    output logic [XLEN-1:0] core_rd_o,
    output logic            core_stall_o,
    output logic            core_err_o,
    output logic            mem_req_o,
    output logic            mem_we_o,
    output logic [XLEN-1:0] mem_addr_o,
    output logic [XLEN-1:0] mem_wd_o,
    input  logic [XLEN-1:0] mem_rd_i
);

    state_e          state_q, state_d;
    logic [XLEN-1:0] addr_q;
    logic [SZW-1:0]  size_q;
    logic [15:0]     wd_q;
    logic [XLEN-1:0] last_rd_q;
    logic            latch_en;
    logic            capture;
    logic [XLEN-1:0] load_data;
    logic [XLEN-1:0] merge_data;

    lsu_byte_lane u_lane (
        .size       (size_q),
        .addr_lo    (addr_q[1:0]),
        .rd_word    (mem_rd_i),
        .wd         (wd_q),
        .load_data  (load_data),
        .merge_data (merge_data)
    );

    // Word-aligned address: live from the core when idle, latched during a transaction.
    assign mem_addr_o = (state_q == ST_IDLE) ? {core_addr_i[31:2], 2'b00}
                                             : {addr_q[31:2], 2'b00};

    // State, request latches and last load result.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            size_q    <= SIZE_B;
            wd_q      <= '0;
            last_rd_q <= '0;
        end else begin
            state_q <= state_d;
            if (latch_en) begin
                addr_q <= core_addr_i;
                size_q <= core_size_i;
                wd_q   <= core_wd_i[15:0];
            end
            if (capture) begin
                last_rd_q <= load_data;
            end
        end
    end

    // Next state and memory/core handshake outputs.
    always_comb begin
        state_d      = state_q;
        latch_en     = 1'b0;
        capture      = 1'b0;
        mem_req_o    = 1'b0;
        mem_we_o     = 1'b0;
        mem_wd_o     = '0;
        core_stall_o = 1'b0;
        core_err_o   = 1'b0;
        core_rd_o    = last_rd_q;

        case (state_q)
            ST_IDLE: begin
                if (core_req_i) begin
                    if (access_bad(core_we_i, core_size_i, core_addr_i[1:0])) begin
                        core_err_o = 1'b1;
                    end else begin
                        latch_en  = 1'b1;
                        mem_req_o = 1'b1;
                        if (core_we_i && core_size_i == SIZE_W) begin
                            mem_we_o = 1'b1;
                            mem_wd_o = core_wd_i;
                        end else if (core_we_i) begin
                            core_stall_o = 1'b1;
                            state_d      = ST_RMW_MERGE;
                        end else begin
                            core_stall_o = 1'b1;
                            state_d      = ST_LOAD_DATA;
                        end
                    end
                end
            end
            ST_LOAD_DATA: begin
                core_rd_o = load_data;
                capture   = 1'b1;
                state_d   = ST_IDLE;
            end
            ST_RMW_MERGE: begin
                mem_req_o = 1'b1;
                mem_we_o  = 1'b1;
                mem_wd_o  = merge_data;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Reset aborts any transaction in flight: no write, no captured result.
        if (rst_i) begin
            latch_en     = 1'b0;
            capture      = 1'b0;
            mem_req_o    = 1'b0;
            mem_we_o     = 1'b0;
            core_stall_o = 1'b0;
            core_err_o   = 1'b0;
        end
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have ports: clk_i  in  1  system clock, all state on rising edge.
REQ-002 SHALL have ports: rst_i  in  1  reset; one clock; reset is synchronous and active-high.
REQ-003 SHALL have ports: core_req_i  in  1  core memory access request.
REQ-004 SHALL have ports: core_we_i  in  1  1 = store, 0 = load.
REQ-005 SHALL have ports: core_size_i  in  3  access size code (B=0, H=1, W=2, BU=4, HU=5).
REQ-006 SHALL have ports: core_addr_i  in  32  byte address.
REQ-007 SHALL have ports: core_wd_i  in  32  store data, LSB-aligned.
REQ-008 SHALL have ports: core_rd_o  out  32  extended load result.
REQ-009 SHALL have ports: core_stall_o  out  1  core must hold inputs and not advance.
REQ-010 SHALL have ports: core_err_o  out  1  misaligned or illegal-size access.
REQ-011 SHALL have ports: mem_req_o, mem_we_o  out  1 each  data memory request / write enable.
REQ-012 SHALL have ports: mem_addr_o  out  32  always {core_addr_i[31:2],2'b00} in IDLE, latched aligned address otherwise.
REQ-013 SHALL have ports: mem_wd_o  out  32  write data; mem_rd_i  in  32  sync-read data (valid the cycle after a read request).

Function
REQ-014 FSM states SHALL be IDLE, LOAD_DATA, RMW_MERGE; IDLE after reset.
REQ-015 In IDLE with core_req_i=1, SHALL latch addr, size, wd; aligned address drives mem_addr_o.
REQ-016 Illegal (size 3/6/7, or store size 4/5) or misaligned (H/HU with addr[0]=1, W with addr[1:0]!=0) SHALL assert core_err_o combinationally, with mem_req_o=0, stall=0, state unchanged.
REQ-017 Load (IDLE): mem_req_o=1, mem_we_o=0, core_stall_o=1, next LOAD_DATA.
REQ-018 LOAD_DATA: core_rd_o = extend(mem_rd_i) combinationally, core_stall_o=0, result captured into last_rd_q, next IDLE; total latency 2 cycles, stall exactly 1.
REQ-019 Outside LOAD_DATA, core_rd_o SHALL equal last_rd_q.
REQ-020 Extension: B/BU pick byte addr[1:0], H/HU pick half addr[1]; B/H sign-extend, BU/HU zero-extend, W passes through unchanged (incl. 0xdead_beef from out-of-range reads).
REQ-021 SW (IDLE): mem_req_o=1, mem_we_o=1, mem_wd_o=core_wd_i, core_stall_o=0, stay IDLE; single cycle.
REQ-022 SB/SH (IDLE): issue read (mem_we_o=0), stall=1, next RMW_MERGE.
REQ-023 RMW_MERGE: mem_req_o=1, mem_we_o=1, mem_wd_o = mem_rd_i with byte lane addr[1:0] (SB) or half lane addr[1] (SH) replaced by wd[7:0]/wd[15:0]; core_stall_o=0; next IDLE.
REQ-024 No core_req_i in IDLE: mem_req_o=0, mem_we_o=0, mem_wd_o=0, stall=0.
REQ-025 Non-IDLE states SHALL use only latched values; core_req_i SHALL be re-sampled only in IDLE.

Reset
REQ-026 While rst_i=1: mem_req_o=0, mem_we_o=0, core_stall_o=0, core_err_o=0; at the edge state=IDLE, last_rd_q=0.
REQ-027 Reset in LOAD_DATA or RMW_MERGE SHALL abort: no memory write issued, load result discarded.

Structure
REQ-028 Package lsu_pkg SHALL hold size codes and the state enum.
REQ-029 One combinational sub-module lsu_byte_lane SHALL implement load extraction/extension and store merge.

Verification (bench uses data_mem as downstream model)
REQ-030 SW 0x7654_3210 @0, then LW @0 -> stall high 1 cycle, core_rd_o=0x7654_3210 in release cycle.
REQ-031 Word 0xfecd_ba98 @4: LB @7 -> 0xffff_fffe; LBU @7 -> 0x0000_00fe; LH @6 -> 0xffff_fecd; LHU @4 -> 0x0000_ba98.
REQ-032 SB 0x55 @5 over 0xfecd_ba98 -> mem_we_o only in cycle 2, LW @4 returns 0xfecd_5598.
REQ-033 SH @1 and LW @2 -> core_err_o=1, mem_req_o=0, stall=0, memory unchanged.
REQ-034 rst_i asserted in RMW_MERGE -> no write, word unchanged, state IDLE, core_rd_o=0.
REQ-035 LW @0x1000 -> core_rd_o=0xdead_beef.
